// File: rtl/alu_control_md_pkg.sv
// Shared encodings for the ALU control block: MIPS opcodes, R-type funcs,
// COP0 sub-ops, mul/div operation codes and sequencer states.
package alu_control_md_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funcs (also used as ALU control codes)
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;
  localparam logic [5:0] F_ERET  = 6'h18;

  // ALU-only control codes with no R-type func of their own
  localparam logic [5:0] ALU_LUI   = 6'h3C;
  localparam logic [5:0] ALU_ROTR  = 6'h3E;
  localparam logic [5:0] ALU_ROTRV = 6'h3F;

  // COP0 sub-ops (r_field[9:5])
  localparam logic [4:0] C0_MFC0 = 5'b00000;
  localparam logic [4:0] C0_MTC0 = 5'b00100;
  localparam logic [4:0] C0_ERET = 5'b10000;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_control_md_sequencer.sv
// Multi-cycle MULT/DIV sequencer: counts the busy window of the external
// mul-div unit and strobes the HI/LO write when the result is ready.
module alu_control_md_sequencer
  import alu_control_md_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_flush,
  output logic [1:0] o_md_op,
  output logic       o_busy,
  output logic       o_hilo_we
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  md_op_e           r_md_op;

  // State, countdown and latched operation; flush abandons any operation in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_md_op <= MD_MULT;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_md_op <= md_op_e'(i_op);
            r_cnt   <= i_op[1] ? DIV_LOAD : MUL_LOAD;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_md_op   = r_md_op;
  assign o_busy    = (r_state != ST_IDLE);
  // A flush landing on the DONE cycle suppresses the write-back as well.
  assign o_hilo_we = (r_state == ST_DONE) && !i_flush;

endmodule

// File: rtl/alu_control_md.sv
// ALU control decode with a MULT/DIV sequencer and HI/LO hazard interlock.
module alu_control_md
  import alu_control_md_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6,
  parameter bit ROTR_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_flush,
  input  logic [5:0] i_aluOp,
  input  logic [5:0] i_func,
  input  logic [9:0] i_r_field,
  output logic [5:0] o_aluControl,
  output logic       o_ALUSrc_op1,
  output logic       o_jr,
  output logic       o_nop,
  output logic       o_eret,
  output logic       o_mfc0,
  output logic       o_mtc0,
  output logic       o_unknown_func,
  output logic       o_md_start,
  output logic [1:0] o_md_op,
  output logic       o_md_busy,
  output logic       o_hilo_we,
  output logic [1:0] o_mfhilo,
  output logic [1:0] o_mthilo,
  output logic       o_stall
);

  logic       w_is_md;
  logic       w_is_hilo;
  logic [1:0] w_mf;
  logic [1:0] w_mt;
  logic       w_busy;
  logic       w_unused_rfield;

  assign w_unused_rfield = ^i_r_field[4:1];

  // Instruction decode; everything stays 0 unless a live instruction sits in decode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_aluControl   = '0;
    o_ALUSrc_op1   = 1'b0;
    o_jr           = 1'b0;
    o_nop          = 1'b0;
    o_eret         = 1'b0;
    o_mfc0         = 1'b0;
    o_mtc0         = 1'b0;
    o_unknown_func = 1'b0;
    w_is_md        = 1'b0;
    w_is_hilo      = 1'b0;
    w_mf           = 2'b00;
    w_mt           = 2'b00;
    if (i_valid && !i_flush && !i_rst) begin
      case (i_aluOp)
        OP_ADDIU:            o_aluControl = F_ADDU;
        OP_ADDI, OP_LW, OP_SW: o_aluControl = F_ADD;
        OP_BEQ, OP_BNE:      o_aluControl = F_SUB;
        OP_LUI:              o_aluControl = ALU_LUI;
        OP_ORI:              o_aluControl = F_OR;
        OP_XORI:             o_aluControl = F_XOR;
        OP_ANDI:             o_aluControl = F_AND;
        OP_RTYPE: begin
          o_nop = (i_func == 6'h00);
          case (i_func)
            F_SLL, F_SRA: begin
              o_aluControl = i_func;
              o_ALUSrc_op1 = 1'b1;
            end
            F_SRL: begin
              o_aluControl = (ROTR_EN && i_r_field[5]) ? ALU_ROTR : F_SRL;
              o_ALUSrc_op1 = 1'b1;
            end
            F_SRLV: o_aluControl = (ROTR_EN && i_r_field[0]) ? ALU_ROTRV : F_SRLV;
            F_SLLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
            F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU:
              o_aluControl = i_func;
            F_JR: begin
              o_aluControl = i_func;
              o_jr         = 1'b1;
            end
            F_MULT, F_MULTU, F_DIV, F_DIVU: w_is_md = 1'b1;
            F_MFHI: begin w_is_hilo = 1'b1; w_mf = 2'b10; end
            F_MFLO: begin w_is_hilo = 1'b1; w_mf = 2'b01; end
            F_MTHI: begin w_is_hilo = 1'b1; w_mt = 2'b10; end
            F_MTLO: begin w_is_hilo = 1'b1; w_mt = 2'b01; end
            default: o_unknown_func = 1'b1;
          endcase
        end
        OP_COP0: begin
          case (i_r_field[9:5])
            C0_MTC0: o_mtc0 = 1'b1;
            C0_MFC0: o_mfc0 = 1'b1;
            C0_ERET: begin
              if (i_func == F_ERET) o_eret         = 1'b1;
              else                  o_unknown_func = 1'b1;
            end
            default: o_unknown_func = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Any HI/LO consumer or producer waits while the sequencer owns HI/LO.
  assign o_stall    = (w_is_md || w_is_hilo) && w_busy;
  assign o_md_start = w_is_md && !w_busy;
  assign o_mfhilo   = o_stall ? 2'b00 : w_mf;
  assign o_mthilo   = o_stall ? 2'b00 : w_mt;
  assign o_md_busy  = w_busy;

  alu_control_md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_seq (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (o_md_start),
    .i_op      (i_func[1:0]),
    .i_flush   (i_flush),
    .o_md_op   (o_md_op),
    .o_busy    (w_busy),
    .o_hilo_we (o_hilo_we)
  );

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode table, MULT/DIV timing,
// HI/LO interlock, flush/reset abort and the ROTR option.
module tb_alu_control_md;
  import alu_control_md_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       i_flush;
  logic [5:0] i_aluOp;
  logic [5:0] i_func;
  logic [9:0] i_r_field;

  logic [5:0] alu_ctl, alu_ctl0;
  logic       src1, jr, nop, eret, mfc0, mtc0, unk;
  logic       md_start, md_busy, hilo_we, stall;
  logic [1:0] md_op, mfhilo, mthilo;
  logic       src1_0, jr_0, nop_0, eret_0, mfc0_0, mtc0_0, unk_0;
  logic       md_start_0, md_busy_0, hilo_we_0, stall_0;
  logic [1:0] md_op_0, mfhilo_0, mthilo_0;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  alu_control_md #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .ROTR_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_aluOp(i_aluOp), .i_func(i_func), .i_r_field(i_r_field),
    .o_aluControl(alu_ctl), .o_ALUSrc_op1(src1), .o_jr(jr), .o_nop(nop),
    .o_eret(eret), .o_mfc0(mfc0), .o_mtc0(mtc0), .o_unknown_func(unk),
    .o_md_start(md_start), .o_md_op(md_op), .o_md_busy(md_busy),
    .o_hilo_we(hilo_we), .o_mfhilo(mfhilo), .o_mthilo(mthilo), .o_stall(stall)
  );

  alu_control_md #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .ROTR_EN(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_aluOp(i_aluOp), .i_func(i_func), .i_r_field(i_r_field),
    .o_aluControl(alu_ctl0), .o_ALUSrc_op1(src1_0), .o_jr(jr_0), .o_nop(nop_0),
    .o_eret(eret_0), .o_mfc0(mfc0_0), .o_mtc0(mtc0_0), .o_unknown_func(unk_0),
    .o_md_start(md_start_0), .o_md_op(md_op_0), .o_md_busy(md_busy_0),
    .o_hilo_we(hilo_we_0), .o_mfhilo(mfhilo_0), .o_mthilo(mthilo_0), .o_stall(stall_0)
  );

  // {src1, jr, nop, eret, mfc0, mtc0, unknown}
  function automatic logic [6:0] flags();
    return {src1, jr, nop, eret, mfc0, mtc0, unk};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [9:0] rf);
    i_valid   = v;
    i_aluOp   = op;
    i_func    = fn;
    i_r_field = rf;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(1'b0, 6'h00, 6'h00, 10'h000);
    end
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_flush = 1'b0;
    drive(1'b1, OP_ADDIU, 6'h00, 10'h000);
    checks++;
    if (alu_ctl !== 6'h00 || flags() !== 7'h00) begin
      errors++; $display("FAIL reset_decode: got alu=%h flags=%b want 00/0000000", alu_ctl, flags());
    end
    checks++;
    if (md_busy !== 1'b0 || hilo_we !== 1'b0 || md_op !== 2'b00 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_seq: got busy=%b we=%b op=%b stall=%b want 0/0/00/0",
                         md_busy, hilo_we, md_op, stall);
    end
    tick();
    tick();
    i_rst = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 10'h000);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [9:0] rf;
    logic [5:0] alu;
    logic [6:0] fl;
  } dec_vec_t;

  task automatic test_decode();
    dec_vec_t v[24];
    v[0]  = '{OP_ADDIU, 6'h00, 10'h000, 6'h21, 7'b0000000};
    v[1]  = '{OP_ADDI,  6'h00, 10'h000, 6'h20, 7'b0000000};
    v[2]  = '{OP_LW,    6'h00, 10'h000, 6'h20, 7'b0000000};
    v[3]  = '{OP_SW,    6'h00, 10'h000, 6'h20, 7'b0000000};
    v[4]  = '{OP_BEQ,   6'h00, 10'h000, 6'h22, 7'b0000000};
    v[5]  = '{OP_BNE,   6'h00, 10'h000, 6'h22, 7'b0000000};
    v[6]  = '{OP_LUI,   6'h00, 10'h000, 6'h3C, 7'b0000000};
    v[7]  = '{OP_ORI,   6'h00, 10'h000, 6'h25, 7'b0000000};
    v[8]  = '{OP_XORI,  6'h00, 10'h000, 6'h26, 7'b0000000};
    v[9]  = '{OP_ANDI,  6'h00, 10'h000, 6'h24, 7'b0000000};
    v[10] = '{OP_RTYPE, 6'h21, 10'h000, 6'h21, 7'b0000000};
    v[11] = '{OP_RTYPE, 6'h2A, 10'h000, 6'h2A, 7'b0000000};
    v[12] = '{OP_RTYPE, 6'h00, 10'h000, 6'h00, 7'b1010000};
    v[13] = '{OP_RTYPE, 6'h03, 10'h000, 6'h03, 7'b1000000};
    v[14] = '{OP_RTYPE, 6'h02, 10'h000, 6'h02, 7'b1000000};
    v[15] = '{OP_RTYPE, 6'h08, 10'h000, 6'h08, 7'b0100000};
    v[16] = '{OP_RTYPE, 6'h10, 10'h000, 6'h00, 7'b0000000};
    v[17] = '{OP_RTYPE, 6'h3F, 10'h000, 6'h00, 7'b0000001};
    v[18] = '{OP_RTYPE, 6'h01, 10'h000, 6'h00, 7'b0000001};
    v[19] = '{OP_COP0,  6'h00, 10'h080, 6'h00, 7'b0000010};
    v[20] = '{OP_COP0,  6'h00, 10'h000, 6'h00, 7'b0000100};
    v[21] = '{OP_COP0,  6'h18, 10'h200, 6'h00, 7'b0001000};
    v[22] = '{OP_COP0,  6'h00, 10'h200, 6'h00, 7'b0000001};
    v[23] = '{OP_J,     6'h00, 10'h000, 6'h00, 7'b0000000};
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, v[i].op, v[i].fn, v[i].rf);
      checks++;
      if (alu_ctl !== v[i].alu || flags() !== v[i].fl) begin
        errors++;
        $display("FAIL decode[%0d]: got alu=%h flags=%b want alu=%h flags=%b",
                 i, alu_ctl, flags(), v[i].alu, v[i].fl);
      end
    end
    drive(1'b1, OP_RTYPE, F_MFHI, 10'h000);
    checks++;
    if (mfhilo !== 2'b10 || stall !== 1'b0) begin
      errors++; $display("FAIL mfhi_idle: got mfhilo=%b stall=%b want 10/0", mfhilo, stall);
    end
    drive(1'b1, OP_RTYPE, F_MTLO, 10'h000);
    checks++;
    if (mthilo !== 2'b01) begin
      errors++; $display("FAIL mtlo_idle: got mthilo=%b want 01", mthilo);
    end
    drive(1'b0, OP_ADDIU, 6'h00, 10'h000);
    checks++;
    if (alu_ctl !== 6'h00 || flags() !== 7'h00) begin
      errors++; $display("FAIL valid0: got alu=%h flags=%b want 00/0000000", alu_ctl, flags());
    end
    i_flush = 1'b1;
    drive(1'b1, OP_RTYPE, 6'h00, 10'h000);
    checks++;
    if (alu_ctl !== 6'h00 || flags() !== 7'h00) begin
      errors++; $display("FAIL flush_decode: got alu=%h flags=%b want 00/0000000", alu_ctl, flags());
    end
    i_flush = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 10'h000);
  endtask

  task automatic test_rotr();
    drive(1'b1, OP_RTYPE, F_SRL, 10'h020);
    checks++;
    if (alu_ctl !== 6'h3E || src1 !== 1'b1) begin
      errors++; $display("FAIL rotr_en1: got alu=%h src1=%b want 3e/1", alu_ctl, src1);
    end
    checks++;
    if (alu_ctl0 !== 6'h02 || src1_0 !== 1'b1) begin
      errors++; $display("FAIL rotr_en0: got alu=%h src1=%b want 02/1", alu_ctl0, src1_0);
    end
    drive(1'b1, OP_RTYPE, F_SRLV, 10'h001);
    checks++;
    if (alu_ctl !== 6'h3F || src1 !== 1'b0) begin
      errors++; $display("FAIL rotrv_en1: got alu=%h src1=%b want 3f/0", alu_ctl, src1);
    end
    checks++;
    if (alu_ctl0 !== 6'h06) begin
      errors++; $display("FAIL rotrv_en0: got alu=%h want 06", alu_ctl0);
    end
    drive(1'b0, 6'h00, 6'h00, 10'h000);
  endtask

  task automatic test_mult();
    tick();
    drive(1'b1, OP_RTYPE, F_MULT, 10'h000);
    checks++;
    if (md_start !== 1'b1 || md_busy !== 1'b0) begin
      errors++; $display("FAIL mult_start: got start=%b busy=%b want 1/0", md_start, md_busy);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      drive(1'b0, 6'h00, 6'h00, 10'h000);
      if (c == 1) begin
        checks++;
        if (md_op !== 2'b00) begin
          errors++; $display("FAIL mult_op: got %b want 00", md_op);
        end
      end
      checks++;
      if (hilo_we !== (c == 5)) begin
        errors++; $display("FAIL mult_we@T+%0d: got %b want %b", c, hilo_we, (c == 5));
      end
      if (c != 5) begin
        checks++;
        if (md_busy !== (c <= 4)) begin
          errors++; $display("FAIL mult_busy@T+%0d: got %b want %b", c, md_busy, (c <= 4));
        end
      end
    end
  endtask

  task automatic test_divu_mflo();
    tick();
    drive(1'b1, OP_RTYPE, F_DIVU, 10'h000);
    checks++;
    if (md_start !== 1'b1) begin
      errors++; $display("FAIL divu_start: got %b want 1", md_start);
    end
    for (int c = 1; c <= 34; c++) begin
      tick();
      drive(1'b1, OP_RTYPE, F_MFLO, 10'h000);
      if (c == 1) begin
        checks++;
        if (md_op !== 2'b11) begin
          errors++; $display("FAIL divu_op: got %b want 11", md_op);
        end
      end
      checks++;
      if (stall !== (c <= 33)) begin
        errors++; $display("FAIL divu_stall@T+%0d: got %b want %b", c, stall, (c <= 33));
      end
      checks++;
      if (mfhilo !== ((c == 34) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL divu_mfhilo@T+%0d: got %b want %b", c, mfhilo,
                           ((c == 34) ? 2'b01 : 2'b00));
      end
      if (c == 33) begin
        checks++;
        if (hilo_we !== 1'b1) begin
          errors++; $display("FAIL divu_we: got %b want 1", hilo_we);
        end
      end
    end
    drive(1'b0, 6'h00, 6'h00, 10'h000);
  endtask

  task automatic test_interlock();
    tick();
    drive(1'b1, OP_RTYPE, F_MULT, 10'h000);
    tick();
    drive(1'b1, OP_RTYPE, F_ADDU, 10'h000);
    checks++;
    if (stall !== 1'b0 || alu_ctl !== 6'h21) begin
      errors++; $display("FAIL addu_busy: got stall=%b alu=%h want 0/21", stall, alu_ctl);
    end
    idle_cycles(3);
    tick();
    drive(1'b1, OP_RTYPE, F_MTHI, 10'h000);
    checks++;
    if (stall !== 1'b1 || mthilo !== 2'b00 || hilo_we !== 1'b1) begin
      errors++; $display("FAIL mthi_done: got stall=%b mthilo=%b we=%b want 1/00/1",
                         stall, mthilo, hilo_we);
    end
    tick();
    drive(1'b1, OP_RTYPE, F_MTHI, 10'h000);
    checks++;
    if (stall !== 1'b0 || mthilo !== 2'b10) begin
      errors++; $display("FAIL mthi_idle: got stall=%b mthilo=%b want 0/10", stall, mthilo);
    end
    drive(1'b0, 6'h00, 6'h00, 10'h000);
  endtask

  task automatic test_back_to_back();
    tick();
    drive(1'b1, OP_RTYPE, F_MULT, 10'h000);
    for (int c = 1; c <= 6; c++) begin
      tick();
      drive(1'b1, OP_RTYPE, F_MULTU, 10'h000);
      checks++;
      if (md_start !== (c == 6) || stall !== (c <= 5)) begin
        errors++; $display("FAIL b2b@T+%0d: got start=%b stall=%b want %b/%b",
                           c, md_start, stall, (c == 6), (c <= 5));
      end
    end
    tick();
    drive(1'b0, 6'h00, 6'h00, 10'h000);
    checks++;
    if (md_op !== 2'b01) begin
      errors++; $display("FAIL b2b_op: got %b want 01", md_op);
    end
    idle_cycles(6);
  endtask

  task automatic test_flush();
    tick();
    drive(1'b1, OP_RTYPE, F_DIV, 10'h000);
    tick();
    drive(1'b0, 6'h00, 6'h00, 10'h000);
    tick();
    i_flush = 1'b1;
    drive(1'b0, 6'h00, 6'h00, 10'h000);
    checks++;
    if (md_busy !== 1'b1 || hilo_we !== 1'b0) begin
      errors++; $display("FAIL flush_t2: got busy=%b we=%b want 1/0", md_busy, hilo_we);
    end
    tick();
    i_flush = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 10'h000);
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got busy=%b want 0", md_busy);
    end
    for (int c = 0; c < 36; c++) begin
      tick();
      checks++;
      if (hilo_we !== 1'b0) begin
        errors++; $display("FAIL flush_we@%0d: got %b want 0", c, hilo_we);
      end
    end
    i_flush = 1'b1;
    drive(1'b1, OP_RTYPE, F_MULT, 10'h000);
    checks++;
    if (md_start !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL flush_wins: got start=%b stall=%b want 0/0", md_start, stall);
    end
    tick();
    i_flush = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 10'h000);
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL flush_nostart: got busy=%b want 0", md_busy);
    end
  endtask

  task automatic test_reset_mid_op();
    tick();
    drive(1'b1, OP_RTYPE, F_MULTU, 10'h000);
    tick();
    drive(1'b0, 6'h00, 6'h00, 10'h000);
    tick();
    i_rst = 1'b1;
    #1;
    checks++;
    if (md_busy !== 1'b0 || md_op !== 2'b00) begin
      errors++; $display("FAIL rst_async: got busy=%b op=%b want 0/00", md_busy, md_op);
    end
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (hilo_we !== 1'b0 || md_busy !== 1'b0) begin
        errors++; $display("FAIL rst_we@%0d: got we=%b busy=%b want 0/0", c, hilo_we, md_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_rotr();
    test_mult();
    test_divu_mflo();
    test_interlock();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
